addsub_pipe: RTL
================

ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits (legal 2..64).
REQ-002 Parameter: SAT, 0, 1 = clamp results on signed overflow; 0 = two's-complement wrap.
REQ-003 Port: clk  in  1  sole clock; all state on rising edge.
REQ-004 Port: rst_n  in  1  reset; asynchronous assert, active-low.
REQ-005 Port: in_valid  in  1  operation request.
REQ-006 Port: in_ready  out  1  block can accept request this cycle.
REQ-007 Port: op  in  2  00 A+B, 01 A-B, 10 ACC+A, 11 ACC-A.
REQ-008 Port: a  in  WIDTH  operand A.
REQ-009 Port: b  in  WIDTH  operand B; ignored for op 1x.
REQ-010 Port: clr  in  1  single-cycle clear of accumulator and sticky flag.
REQ-011 Port: out_valid  out  1  result registers hold an unconsumed result.
REQ-012 Port: out_ready  in  1  downstream consumes result this cycle.
REQ-013 Port: result  out  WIDTH  operation result.
REQ-014 Port: carry_out  out  1  MSB carry; for subtraction 1 = no borrow.
REQ-015 Port: overflow  out  1  signed overflow of this result.
REQ-016 Port: zero, negative  out  1 each  result==0; result[WIDTH-1].
REQ-017 Port: ovf_sticky  out  1  set by any overflow since last clr/reset.

Function
REQ-018 Accept on in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-019 Two register stages: S1 (operands, op), S2 (result, flags); an accepted request reaches S2 on the second rising edge after acceptance when unstalled.
REQ-020 S2 loads when S1 valid and (!out_valid || out_ready); S1 loads when in_ready.
REQ-021 in_ready = !s1_valid || S2 loads this cycle (full throughput of one op/cycle under out_ready=1).
REQ-022 Subtraction computed as X + ~Y + 1 on WIDTH bits; X = A (op 0x) or ACC (op 1x); Y = B (op 00/01) or A (op 10/11).
REQ-023 overflow = carry into MSB XOR carry out of MSB.
REQ-024 SAT=1 and overflow: result = 0111..1 if X is non-negative, else 1000..0; carry_out and overflow reported unmodified.
REQ-025 zero and negative derived from the final (possibly clamped) result.
REQ-026 Accumulator (WIDTH bits) updated with the final result only on S1->S2 transfer of op 1x; ops 0x leave it unchanged.
REQ-027 Back-to-back ACC ops each use the accumulator value written by the immediately preceding ACC op (no hazard).
REQ-028 clr on an edge with no ACC transfer: ACC=0, ovf_sticky=0.
REQ-029 clr on the same edge as an ACC transfer: that op uses ACC=0 and its result is stored in ACC.
REQ-030 clr on the same edge as an overflowing S2 load: ovf_sticky=1 (new overflow wins).
REQ-031 Outputs stable while out_valid && !out_ready; no request dropped, duplicated, or reordered.

Reset
REQ-032 rst_n low: out_valid=0, S1 valid=0, result=0, carry_out=overflow=zero=negative=0, ovf_sticky=0, ACC=0, immediately and asynchronously.
REQ-033 in_ready=1 while in reset and on first cycle after release; in-flight requests at reset are discarded.

Verification (WIDTH=8)
REQ-034 SAT=0, op 00, a=0x7F, b=0x01 -> 2 edges later result=0x80, overflow=1, carry_out=0, negative=1, ovf_sticky=1.
REQ-035 SAT=1, same stimulus -> result=0x7F, overflow=1, negative=0; op 01 a=0x80 b=0x01 -> result=0x80, overflow=1.
REQ-036 op 01 a=0x05 b=0x07 -> 0xFE, carry_out=0, overflow=0; a=0x07 b=0x07 -> 0x00, zero=1, carry_out=1.
REQ-037 clr, then ops 10/10/11 with a=10,20,5 back-to-back -> results 10,30,25 on consecutive cycles; clr coincident with 4th op 10 a=3 -> result 3.
REQ-038 out_ready=0 with 4 consecutive valid requests -> in_ready falls after 2 accepted; on out_ready=1 all results emerge in order, none lost.
REQ-039 rst_n low while S1 and S2 hold data -> out_valid=0, ACC=0, ovf_sticky=0 at once; first post-reset op 00 1+2 -> result 3 with no stale output.

Source files
------------

// File: rtl/addsub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | addsub_pipe                                                                |
// | Two-stage add/subtract pipeline with an accumulator and optional signed    |
// | saturation. It uses a valid/ready handshake on both the input and output.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module addsub_pipe #(
  parameter int WIDTH = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             ovf_sticky
);

  localparam logic [WIDTH-1:0] c_MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             r_s1_valid;
  logic [1:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;
  logic             r_sticky;

  logic             w_s2_load;
  logic             w_acc_xfer;
  logic             w_sub;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] w_y_eff;
  logic [WIDTH-2:0] w_low;
  logic             w_c_into_msb;
  logic             w_msb;
  logic             w_cout;
  logic             w_ovf;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_final;

  assign w_s2_load  = r_s1_valid && (!r_out_valid || out_ready);
  assign in_ready   = !r_s1_valid || w_s2_load;
  assign w_acc_xfer = w_s2_load && r_s1_op[1];

  // A clear that lands on the same edge as an ACC op makes that op start from zero.
  assign w_x     = r_s1_op[1] ? (clr ? '0 : r_acc) : r_s1_a;
  assign w_y     = r_s1_op[1] ? r_s1_a : r_s1_b;
  assign w_sub   = r_s1_op[0];
  assign w_y_eff = w_sub ? ~w_y : w_y;

  // Split the adder at the MSB so the carry into it is visible for overflow.
  assign {w_c_into_msb, w_low} = {1'b0, w_x[WIDTH-2:0]} + {1'b0, w_y_eff[WIDTH-2:0]}
                                 + {{(WIDTH-1){1'b0}}, w_sub};
  assign {w_cout, w_msb} = {1'b0, w_x[WIDTH-1]} + {1'b0, w_y_eff[WIDTH-1]}
                           + {1'b0, w_c_into_msb};
  assign w_raw = {w_msb, w_low};
  assign w_ovf = w_c_into_msb ^ w_cout;

  always_comb begin
    w_final = w_raw;
    if (SAT && w_ovf) begin
      w_final = w_x[WIDTH-1] ? c_MIN_NEG : c_MAX_POS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= 2'b00;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op <= op;
        r_s1_a  <= a;
        r_s1_b  <= b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= 1'b1;
      r_result    <= w_final;
      r_carry     <= w_cout;
      r_ovf       <= w_ovf;
      r_zero      <= (w_final == '0);
      r_neg       <= w_final[WIDTH-1];
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_acc_xfer) begin
      r_acc <= w_final;
    end else if (clr) begin
      r_acc <= '0;
    end
  end

  // A fresh overflow outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_s2_load && w_ovf) begin
      r_sticky <= 1'b1;
    end else if (clr) begin
      r_sticky <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign carry_out  = r_carry;
  assign overflow   = r_ovf;
  assign zero       = r_zero;
  assign negative   = r_neg;
  assign ovf_sticky = r_sticky;

endmodule
`default_nettype wire
